// File: rtl/apb_ssp_pkg.sv
// Shared definitions for the APB initiator bridge: FSM encoding, default
// bus widths and register offsets of the peripherals it talks to.
package apb_ssp_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam logic [7:0] GPO_OFS  = 8'h00;
    localparam logic [7:0] GPI_OFS  = 8'h04;
    localparam logic [7:0] GPID_OFS = 8'h0C;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // Width of a counter that must hold 0..cycles; never narrower than 1 bit.
    function automatic int tmo_cnt_w(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/apb_master_ssp.sv
// APB initiator bridge: turns one valid/ready command into a single APB
// transfer and returns read data or a timeout error on a valid/ready response.
module apb_master_ssp
    import apb_ssp_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clock,
    input  logic                  rst_n,

    // Handshakes: a beat transfers on the rising edge where valid and ready
    // are both high; the sender holds its payload stable while valid is high.
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,

    output logic [ADDR_W-1:0]     apb_addr,
    output logic                  apb_sel,
    output logic                  apb_write,
    output logic                  apb_ena,
    output logic [DATA_W-1:0]     apb_wdata,
    output logic [DATA_W/8-1:0]   apb_pstb,
    input  logic [DATA_W-1:0]     apb_rdata,
    input  logic                  apb_rready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = tmo_cnt_w(TIMEOUT_CYCLES);
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    apb_state_e           state_q, state_d;
    logic [ADDR_W-1:0]    addr_q,  addr_d;
    logic                 write_q, write_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [STRB_W-1:0]    pstb_q,  pstb_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 err_q,   err_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            pstb_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            pstb_q  <= pstb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        pstb_d  = pstb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    write_d = cmd_write;
                    wdata_d = cmd_wdata;
                    pstb_d  = cmd_write ? cmd_strb : '0;
                    cnt_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // Completion is tested first so a ready on the last allowed cycle still succeeds.
                if (apb_rready) begin
                    rdata_d = write_q ? '0 : apb_rdata;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (TMO_EN && (cnt_q == CNT_LAST)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (TMO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake and APB phase strobes are pure state decodes, so an
    // asynchronous reset clears them in the same instant as the state.
    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign apb_sel   = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign apb_ena   = (state_q == ST_ACCESS);

    assign apb_addr  = addr_q;
    assign apb_write = write_q;
    assign apb_wdata = wdata_q;
    assign apb_pstb  = pstb_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_master_ssp.sv
// Bench for apb_master_ssp: two bridges (timeouts 8 and 4) each driving a
// memory-like APB completer with programmable wait states.
module tb_apb_master_ssp;
    import apb_ssp_pkg::*;

    localparam int NI = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int EW = 16 + 32 + 1 + DW;   // {access_len, rsp_cycle, err, rdata}
    localparam int AE = AW + 1 + DW + SW;   // {addr, write, wdata, pstb}

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic          cmd_valid  [NI];
    logic          cmd_ready  [NI];
    logic          cmd_write  [NI];
    logic [AW-1:0] cmd_addr   [NI];
    logic [DW-1:0] cmd_wdata  [NI];
    logic [SW-1:0] cmd_strb   [NI];
    logic          rsp_valid  [NI];
    logic          rsp_ready  [NI];
    logic [DW-1:0] rsp_rdata  [NI];
    logic          rsp_err    [NI];
    logic [AW-1:0] apb_addr   [NI];
    logic          apb_sel    [NI];
    logic          apb_write  [NI];
    logic          apb_ena    [NI];
    logic [DW-1:0] apb_wdata  [NI];
    logic [SW-1:0] apb_pstb   [NI];
    logic [DW-1:0] apb_rdata  [NI];
    logic          apb_rready [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        apb_master_ssp #(
            .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES((g == 0) ? 8 : 4)
        ) dut (
            .clock(clock), .rst_n(rst_n),
            .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]),
            .cmd_write(cmd_write[g]), .cmd_addr(cmd_addr[g]),
            .cmd_wdata(cmd_wdata[g]), .cmd_strb(cmd_strb[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
            .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]),
            .apb_addr(apb_addr[g]), .apb_sel(apb_sel[g]),
            .apb_write(apb_write[g]), .apb_ena(apb_ena[g]),
            .apb_wdata(apb_wdata[g]), .apb_pstb(apb_pstb[g]),
            .apb_rdata(apb_rdata[g]), .apb_rready(apb_rready[g])
        );
    end

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q [NI][$];
    logic [AE-1:0] apb_q [NI][$];
    logic [DW-1:0] ref_mem [NI][16] = '{default: '0};
    logic [DW-1:0] pmem    [NI][16] = '{default: '0};
    int            cur_wait [NI] = '{default: 0};
    int            bp_len   [NI] = '{default: 0};
    int            rsp_count [NI] = '{default: 0};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, need 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: bounded wait expired or unexpected event (cycle %0d)", name, cyc);
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                            input logic [SW-1:0] strb);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < SW; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // ---------------- completer, response consumer and monitor ----------------
    int            acc_cnt    [NI] = '{default: 0};
    int            rsp_age    [NI] = '{default: 0};
    bit            in_resp    [NI] = '{default: 0};
    bit            prev_setup [NI] = '{default: 0};
    int            acc_len    [NI] = '{default: 0};
    logic [AE-1:0] apb_snap   [NI];
    logic [DW:0]   rsp_snap   [NI];

    always @(negedge clock) begin
        logic [3:0]    idx;
        logic [AE-1:0] ea;
        logic [EW-1:0] ee;
        for (int i = 0; i < NI; i++) begin
            if (rst_n && apb_sel[i] && apb_ena[i]) begin
                idx = apb_addr[i][5:2];
                apb_rready[i] = (cur_wait[i] >= 0) && (acc_cnt[i] == cur_wait[i]);
                if (apb_rready[i] && apb_write[i])
                    pmem[i][idx] = merge(pmem[i][idx], apb_wdata[i], apb_pstb[i]);
                apb_rdata[i] = (apb_rready[i] && !apb_write[i]) ? pmem[i][idx] : $urandom;
                acc_cnt[i]++;
            end else begin
                apb_rready[i] = 1'b0;
                apb_rdata[i]  = $urandom;
                acc_cnt[i]    = 0;
            end
            if (rsp_valid[i]) rsp_age[i] = in_resp[i] ? rsp_age[i] + 1 : 0;
            if (bp_len[i] > 0) rsp_ready[i] = rsp_valid[i] && (rsp_age[i] >= bp_len[i]);
            else               rsp_ready[i] = ($urandom_range(0, 3) != 0);
        end

        #2;
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                in_resp[i]    = 1'b0;
                prev_setup[i] = 1'b0;
                acc_len[i]    = 0;
            end else begin
                if (apb_sel[i] && !apb_ena[i]) begin
                    if (apb_q[i].size() == 0) fail("unexpected_setup");
                    else begin
                        ea = apb_q[i].pop_front();
                        check("setup_addr",  apb_addr[i],  ea[AE-1 -: AW]);
                        check("setup_write", apb_write[i], ea[DW+SW]);
                        check("setup_wdata", apb_wdata[i], ea[SW +: DW]);
                        check("setup_pstb",  apb_pstb[i],  ea[SW-1:0]);
                    end
                    apb_snap[i] = {apb_addr[i], apb_write[i], apb_wdata[i], apb_pstb[i]};
                    acc_len[i]  = 0;
                end else if (apb_sel[i] && apb_ena[i]) begin
                    if (acc_len[i] == 0) check("setup_one_cycle", prev_setup[i], 1'b1);
                    check("access_stable", {apb_addr[i], apb_write[i], apb_wdata[i], apb_pstb[i]},
                          apb_snap[i]);
                    acc_len[i]++;
                end
                prev_setup[i] = apb_sel[i] && !apb_ena[i];

                if (rsp_valid[i]) begin
                    if (!in_resp[i]) begin
                        in_resp[i] = 1'b1;
                        rsp_count[i]++;
                        rsp_snap[i] = {rsp_err[i], rsp_rdata[i]};
                        check("sel_ena_drop", {apb_sel[i], apb_ena[i]}, 2'b00);
                        if (exp_q[i].size() == 0) fail("unexpected_rsp");
                        else begin
                            ee = exp_q[i][0];
                            check("access_len", acc_len[i], ee[EW-1 -: 16]);
                            check("rsp_cycle",  cyc,        ee[DW+1 +: 32]);
                            check("rsp_err",    rsp_err[i], ee[DW]);
                            check("rsp_rdata",  rsp_rdata[i], ee[DW-1:0]);
                        end
                    end else begin
                        check("rsp_hold", {rsp_err[i], rsp_rdata[i]}, rsp_snap[i]);
                    end
                    check("cmd_ready_in_resp", cmd_ready[i], 1'b0);
                    if (rsp_ready[i]) begin
                        in_resp[i] = 1'b0;
                        if (exp_q[i].size() != 0) void'(exp_q[i].pop_front());
                    end
                end
            end
        end
    end

    // ---------------- driver and reference model ----------------
    // w = ACCESS wait states before the completer is ready; -1 = never ready.
    task automatic issue(input int i, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [SW-1:0] strb, input int w);
        int            n;
        int            tmo;
        int            lat;
        int            acc;
        logic          err;
        logic [DW-1:0] data;
        logic [3:0]    idx;
        @(negedge clock);
        cmd_valid[i] = 1'b1;
        cmd_write[i] = wr;
        cmd_addr[i]  = addr;
        cmd_wdata[i] = wd;
        cmd_strb[i]  = strb;
        n = 0;
        while (!cmd_ready[i] && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (!cmd_ready[i]) begin
            fail("cmd_accept_timeout");
            cmd_valid[i] = 1'b0;
            return;
        end
        check("one_outstanding", exp_q[i].size(), 0);
        cur_wait[i] = w;
        tmo = (i == 0) ? 8 : 4;
        idx = addr[5:2];
        if (w >= 0 && w < tmo) begin
            lat  = 3 + w;
            acc  = w + 1;
            err  = 1'b0;
            data = wr ? '0 : ref_mem[i][idx];
            if (wr) ref_mem[i][idx] = merge(ref_mem[i][idx], wd, strb);
        end else begin
            lat  = 2 + tmo;
            acc  = tmo;
            err  = 1'b1;
            data = '0;
        end
        exp_q[i].push_back({16'(acc), 32'(cyc + lat), err, data});
        apb_q[i].push_back({addr, wr, wd, wr ? strb : {SW{1'b0}}});
        @(negedge clock);
        cmd_valid[i] = 1'b0;
        cmd_addr[i]  = $urandom;
        cmd_wdata[i] = $urandom;
        cmd_strb[i]  = SW'($urandom_range(0, 15));
        cmd_write[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input int i);
        int n;
        n = 0;
        while (exp_q[i].size() != 0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (exp_q[i].size() != 0) fail("drain_timeout");
    endtask

    task automatic check_reset_values(input int i);
        check("rst_cmd_ready", cmd_ready[i], 1'b1);
        check("rst_rsp_valid", rsp_valid[i], 1'b0);
        check("rst_rsp_err",   rsp_err[i],   1'b0);
        check("rst_rsp_rdata", rsp_rdata[i], 0);
        check("rst_apb_sel",   apb_sel[i],   1'b0);
        check("rst_apb_ena",   apb_ena[i],   1'b0);
        check("rst_apb_write", apb_write[i], 1'b0);
        check("rst_apb_addr",  apb_addr[i],  0);
        check("rst_apb_wdata", apb_wdata[i], 0);
        check("rst_apb_pstb",  apb_pstb[i],  0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int         ii;
        int         rc;
        int         n;
        logic [3:0] ai;
        for (int i = 0; i < NI; i++) begin
            cmd_valid[i] = 1'b0;
            cmd_write[i] = 1'b0;
            cmd_addr[i]  = '0;
            cmd_wdata[i] = '0;
            cmd_strb[i]  = '0;
        end
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) check_reset_values(i);
        repeat (3) @(negedge clock);
        rst_n = 1'b1;

        // zero-wait write to GPO and read-back
        issue(0, 1'b1, AW'(GPO_OFS), 32'h000A5A5A, 4'hF, 0);
        issue(0, 1'b0, AW'(GPO_OFS), 32'h0, 4'h0, 0);
        // read with three wait states
        issue(0, 1'b1, AW'(GPI_OFS), 32'h12345678, 4'hF, 0);
        issue(0, 1'b0, AW'(GPI_OFS), 32'h0, 4'h0, 3);
        // partial-strobe write then read
        issue(0, 1'b1, AW'(GPID_OFS), 32'hFFFFFFFF, 4'hF, 1);
        issue(0, 1'b1, AW'(GPID_OFS), 32'h11223344, 4'b0101, 2);
        issue(0, 1'b0, AW'(GPID_OFS), 32'h0, 4'h0, 0);
        // timeout (8 cycles): read and write that never complete
        issue(0, 1'b0, AW'(GPO_OFS), 32'h0, 4'h0, -1);
        issue(0, 1'b1, AW'(GPO_OFS), 32'hDEADBEEF, 4'hF, -1);
        issue(0, 1'b0, AW'(GPO_OFS), 32'h0, 4'h0, 7);
        wait_done(0);

        // response backpressure with the next command already waiting
        bp_len[0] = 5;
        issue(0, 1'b0, AW'(GPI_OFS), 32'h0, 4'h0, 0);
        issue(0, 1'b0, AW'(GPO_OFS), 32'h0, 4'h0, 1);
        bp_len[0] = 0;
        wait_done(0);

        // timeout boundary on the 4-cycle instance
        issue(1, 1'b1, 32'h08, 32'hCAFE0001, 4'hF, 0);
        issue(1, 1'b0, 32'h08, 32'h0, 4'h0, 3);
        issue(1, 1'b0, 32'h08, 32'h0, 4'h0, 4);
        wait_done(1);

        // randomized traffic on both instances
        for (int k = 0; k < 40; k++) begin
            ii = $urandom_range(0, NI - 1);
            ai = 4'($urandom_range(0, 15));
            issue(ii, 1'($urandom_range(0, 1)), {26'd0, ai, 2'b00}, $urandom,
                  SW'($urandom_range(0, 15)), int'($urandom_range(0, 10)) - 1);
        end
        wait_done(0);
        wait_done(1);

        // reset in the middle of a wait-state read
        issue(0, 1'b0, AW'(GPI_OFS), 32'h0, 4'h0, 20);
        n = 0;
        while (!(apb_sel[0] && apb_ena[0]) && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!(apb_sel[0] && apb_ena[0])) fail("reach_access");
        repeat (2) @(negedge clock);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_apb_sel",   apb_sel[0],   1'b0);
        check("midrst_apb_ena",   apb_ena[0],   1'b0);
        check("midrst_rsp_valid", rsp_valid[0], 1'b0);
        check("midrst_cmd_ready", cmd_ready[0], 1'b1);
        check("midrst_apb_addr",  apb_addr[0],  0);
        exp_q[0].delete();
        apb_q[0].delete();
        rc = rsp_count[0];
        @(negedge clock);
        #3 rst_n = 1'b1;
        repeat (20) @(negedge clock);
        check("no_rsp_after_reset", rsp_count[0], rc);

        // bridge works again after the abandoned transfer
        issue(0, 1'b0, AW'(GPI_OFS), 32'h0, 4'h0, 2);
        issue(0, 1'b1, AW'(GPO_OFS), 32'h5A5A0000, 4'hC, 0);
        issue(0, 1'b0, AW'(GPO_OFS), 32'h0, 4'h0, 0);
        wait_done(0);
        wait_done(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
